// File: rtl/slr_credit_bridge_if.sv
// AXI-Stream bundle used on both sides of the SLR credit bridge.
interface slr_credit_bridge_if #(
  parameter int unsigned DATA_W = 512
);
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tlast, tvalid, input tready);
  modport slave  (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/slr_credit_bridge.sv
// Credit-flow-controlled AXI-Stream pipeline across an SLR boundary: registered forward
// path, registered credit-return path, FWFT receive FIFO with registered outputs.
module slr_credit_bridge #(
  parameter int unsigned DATA_W      = 512,
  parameter int unsigned PIPE_STAGES = 4,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  slr_credit_bridge_if.slave          s_axis,
  slr_credit_bridge_if.master         m_axis,
  output logic [$clog2(FIFO_DEPTH):0] credit_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        err_overflow
);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BeatW = DATA_W + 1;

  if (PIPE_STAGES < 1 || PIPE_STAGES > 8) begin : g_bad_stages
    $fatal(1, "slr_credit_bridge: PIPE_STAGES must be in 1..8");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_pow2
    $fatal(1, "slr_credit_bridge: FIFO_DEPTH must be a power of two");
  end
  if (FIFO_DEPTH < 2 * PIPE_STAGES + 2) begin : g_bad_depth
    $fatal(1, "slr_credit_bridge: FIFO_DEPTH must be >= 2*PIPE_STAGES+2");
  end

  logic [CntW-1:0]        credit_q, credit_d;
  logic [PIPE_STAGES-1:0] fwd_valid_q;
  logic [BeatW-1:0]       fwd_beat_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] tok_q;

  logic [BeatW-1:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q, head_idx;
  logic [CntW-1:0]        level_q, level_d, level_after_pop;
  logic                   out_valid_q, out_valid_d;
  logic [BeatW-1:0]       out_beat_q, out_beat_d;
  logic                   err_q;

  logic accept, pop, tok_out, wr_en, wr_ok;

  assign s_axis.tready = (credit_q != '0);
  assign accept        = s_axis.tvalid & s_axis.tready;
  assign pop           = out_valid_q & m_axis.tready;
  assign tok_out       = tok_q[PIPE_STAGES-1];
  assign wr_en         = fwd_valid_q[PIPE_STAGES-1];
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_ok         = wr_en & ((level_q != CntW'(FIFO_DEPTH)) | pop);

  always_comb begin
    credit_d        = credit_q - CntW'(accept) + CntW'(tok_out);
    level_after_pop = level_q - CntW'(pop);
    level_d         = level_after_pop + CntW'(wr_ok);
    head_idx        = rd_ptr_q + PtrW'(pop);
    // Only entries already stored before this edge may be presented, so a fresh write
    // appears on the output one cycle after it lands.
    out_valid_d     = (level_after_pop != '0);
    out_beat_d      = out_beat_q;
    if (out_valid_d) begin
      out_beat_d = mem_q[head_idx];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fwd_valid_q <= '0;
      tok_q       <= '0;
      credit_q    <= CntW'(FIFO_DEPTH);
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_beat_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      fwd_valid_q[0] <= accept;
      tok_q[0]       <= pop;
      for (int i = 1; i < int'(PIPE_STAGES); i++) begin
        fwd_valid_q[i] <= fwd_valid_q[i-1];
        tok_q[i]       <= tok_q[i-1];
      end
      credit_q    <= credit_d;
      level_q     <= level_d;
      rd_ptr_q    <= head_idx;
      out_valid_q <= out_valid_d;
      out_beat_q  <= out_beat_d;
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (wr_en && !wr_ok) begin
        err_q <= 1'b1;
      end
    end
  end

  // Data-only storage: no reset so the SLR-crossing registers stay plain flops.
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      fwd_beat_q[0] <= {s_axis.tlast, s_axis.tdata};
    end
    for (int i = 1; i < int'(PIPE_STAGES); i++) begin
      fwd_beat_q[i] <= fwd_beat_q[i-1];
    end
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= fwd_beat_q[PIPE_STAGES-1];
    end
  end

  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tdata  = out_beat_q[DATA_W-1:0];
  assign m_axis.tlast  = out_beat_q[DATA_W];
  assign credit_cnt    = credit_q;
  assign fifo_level    = level_q;
  assign err_overflow  = err_q;

endmodule

// File: tb/tb_slr_credit_bridge.sv
// Randomized self-checking bench for slr_credit_bridge against a queue-based timing model.
module tb_slr_credit_bridge;
  localparam int unsigned DW = 512;
  localparam int unsigned PS = 4;
  localparam int unsigned FD = 16;
  localparam int unsigned CW = $clog2(FD) + 1;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic [CW-1:0] credit_cnt;
  logic [CW-1:0] fifo_level;
  logic          err_overflow;

  slr_credit_bridge_if #(.DATA_W(DW)) s_if ();
  slr_credit_bridge_if #(.DATA_W(DW)) m_if ();

  slr_credit_bridge #(
    .DATA_W     (DW),
    .PIPE_STAGES(PS),
    .FIFO_DEPTH (FD)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .credit_cnt  (credit_cnt),
    .fifo_level  (fifo_level),
    .err_overflow(err_overflow)
  );

  always #5 sys_clk = ~sys_clk;

  // Model: every accepted beat carries the edge it was accepted on; it lands in the FIFO
  // PS edges later, may be shown one edge after that, and each pop returns a credit PS
  // edges after the pop.
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            t;
  } beat_t;

  beat_t sb[$];
  int    pop_t[$];
  int    cyc, n_acc, n_ret, n_pops;
  int    n_checks, n_pass;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int exp_credit();
    return int'(FD) - n_acc + n_ret;
  endfunction

  function automatic int exp_level();
    int n = 0;
    foreach (sb[i]) if (sb[i].t + int'(PS) <= cyc) n++;
    return n;
  endfunction

  function automatic logic exp_valid();
    return (sb.size() != 0) && (sb[0].t + int'(PS) + 1 <= cyc);
  endfunction

  task automatic check_cycle();
    check("credit_cnt", DW'(credit_cnt), DW'(exp_credit()));
    check("fifo_level", DW'(fifo_level), DW'(exp_level()));
    check("s_tready", DW'(s_if.tready), DW'(exp_credit() != 0));
    check("m_tvalid", DW'(m_if.tvalid), DW'(exp_valid()));
    check("err_overflow", DW'(err_overflow), '0);
    if (exp_valid()) begin
      check("m_tdata", m_if.tdata, sb[0].data);
      check("m_tlast", DW'(m_if.tlast), DW'(sb[0].last));
    end
  endtask

  task automatic tick();
    logic  acc, pp;
    beat_t b;
    acc    = s_if.tvalid && (exp_credit() != 0);
    pp     = exp_valid() && m_if.tready;
    b.data = s_if.tdata;
    b.last = s_if.tlast;
    b.t    = 0;
    @(posedge sys_clk);
    cyc++;
    if (pp) begin
      void'(sb.pop_front());
      pop_t.push_back(cyc);
      n_pops++;
    end
    if (acc) begin
      b.t = cyc;
      sb.push_back(b);
      n_acc++;
    end
    while (pop_t.size() != 0 && pop_t[0] + int'(PS) <= cyc) begin
      void'(pop_t.pop_front());
      n_ret++;
    end
    #1;
    check_cycle();
  endtask

  task automatic drain(input int budget);
    int k = 0;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    while ((sb.size() != 0 || pop_t.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    check("drain_done", DW'(sb.size() + pop_t.size()), '0);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int w = 0; w < int'(DW / 32); w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  always @(posedge sys_clk) begin
    if (sys_rst_n) begin
      a_no_overflow: assert (!err_overflow) else $error("overflow flag raised at cycle %0d", cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, bubbles, drops, out0, k, acc_cnt, pop_cyc, sent;
    logic seen, pending;

    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    sys_rst_n   = 1'b1;
    #1 sys_rst_n = 1'b0;
    #20;
    check("rst_credit", DW'(credit_cnt), DW'(FD));
    check("rst_level", DW'(fifo_level), '0);
    check("rst_err", DW'(err_overflow), '0);
    check("rst_m_tvalid", DW'(m_if.tvalid), '0);
    check("rst_m_tdata", m_if.tdata, '0);
    check("rst_m_tlast", DW'(m_if.tlast), '0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick();
    check("rst_s_tready", DW'(s_if.tready), DW'(1));

    // Single beat latency and credit round trip.
    m_if.tready = 1'b1;
    repeat (3) tick();
    s_if.tdata  = DW'(8'hA5);
    s_if.tvalid = 1'b1;
    tick();
    e0 = cyc;
    s_if.tvalid = 1'b0;
    check("single_credit_dec", DW'(credit_cnt), DW'(FD - 1));
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 4) check("single_not_yet", DW'(m_if.tvalid), '0);
      if (i == 5) begin
        check("single_visible", DW'(m_if.tvalid), DW'(1));
        check("single_data", m_if.tdata, DW'(8'hA5));
      end
      if (i == 9) check("single_credit_pending", DW'(credit_cnt), DW'(FD - 1));
      if (i == 10) check("single_credit_back", DW'(credit_cnt), DW'(FD));
    end
    check("single_edge_count", DW'(cyc - e0), DW'(10));

    // 1000-beat back-to-back stream.
    bubbles = 0; drops = 0; seen = 1'b0; out0 = n_pops; sent = 0; k = 0;
    while ((n_pops - out0) < 1000 && k < 1100) begin
      if (sent < 1000) begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = DW'(sent);
        s_if.tlast  = (sent % 7) == 6;
      end else begin
        s_if.tvalid = 1'b0;
      end
      if (sent < 1000 && s_if.tready) sent++;
      else if (sent < 1000) drops++;
      tick();
      k++;
      if (m_if.tvalid) seen = 1'b1;
      else if (seen && (n_pops - out0) < 1000) bubbles++;
    end
    check("stream_out_count", DW'(n_pops - out0), DW'(1000));
    check("stream_bubbles", DW'(bubbles), '0);
    check("stream_ready_drops", DW'(drops), '0);
    drain(40);

    // Downstream stall fills the FIFO exactly.
    m_if.tready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = DW'(32'h1000 + i);
      s_if.tlast  = 1'b0;
      if (s_if.tready) acc_cnt++;
      tick();
    end
    check("stall_accepts", DW'(acc_cnt), DW'(FD));
    check("stall_tready", DW'(s_if.tready), '0);
    check("stall_level", DW'(fifo_level), DW'(FD));
    check("stall_err", DW'(err_overflow), '0);
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    pop_cyc = cyc;
    tick();
    k = 0;
    while (!s_if.tready && k < 20) begin
      tick();
      k++;
    end
    check("stall_pop_to_ready", DW'(cyc - pop_cyc), DW'(PS + 1));
    drain(60);

    // Random gaps on both sides, tlast every 7th beat.
    sent = 0; pending = 1'b0; k = 0;
    while ((sent < 10000 || sb.size() != 0 || pop_t.size() != 0) && k < 60000) begin
      if (!pending && sent < 10000 && $urandom_range(0, 99) >= 30) begin
        s_if.tdata  = rand_data();
        s_if.tlast  = (sent % 7) == 6;
        s_if.tvalid = 1'b1;
        pending     = 1'b1;
      end
      m_if.tready = $urandom_range(0, 99) >= 30;
      acc_cnt = n_acc;
      tick();
      k++;
      if (pending && n_acc != acc_cnt) begin
        pending     = 1'b0;
        sent++;
        s_if.tvalid = 1'b0;
      end
    end
    check("random_sent", DW'(sent), DW'(10000));
    check("random_drained", DW'(sb.size()), '0);

    // Reset while beats are in flight.
    m_if.tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = DW'(32'hDEAD0000 + i);
      tick();
    end
    check("midrst_inflight", DW'(sb.size() >= 6), DW'(1));
    #2 sys_rst_n = 1'b0;
    #1;
    check("midrst_m_tvalid", DW'(m_if.tvalid), '0);
    check("midrst_m_tdata", m_if.tdata, '0);
    check("midrst_m_tlast", DW'(m_if.tlast), '0);
    check("midrst_credit", DW'(credit_cnt), DW'(FD));
    check("midrst_level", DW'(fifo_level), '0);
    sb.delete();
    pop_t.delete();
    n_acc = 0;
    n_ret = 0;
    s_if.tvalid = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick();
    check("postrst_credit", DW'(credit_cnt), DW'(FD));
    repeat (20) tick();
    for (int i = 0; i < 20; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = DW'(32'hBEEF0000 + i);
      tick();
    end
    drain(60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
